// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link: FSM state codes (also used by the
// detector's present_state view), the default pattern width and the reference pattern.
package seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_SEND = 3'd1;
  localparam logic [STATE_W-1:0] ST_GAP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd3;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] REF_PATTERN = 4'b1010;

  function automatic logic is_busy_state(input logic [STATE_W-1:0] s);
    return (s == ST_SEND) || (s == ST_GAP) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first shift register. Exposes the MSB it will hold after the
// coming edge so the owner can register the serial bit without a cycle of lag.
module seq_piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         next_msb
);

  logic [W-1:0] data;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[W-2:0], 1'b0};
    end
  end

  always_comb begin
    next_msb = data[W-1];
    if (load) begin
      next_msb = load_data[W-1];
    end else if (shift) begin
      next_msb = data[W-2];
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern generator: sends a latched pattern MSB-first, repeat_count times,
// with an optional idle gap between repetitions. All outputs are registered.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int   PAT_W    = DEF_PAT_W,
  parameter int   CNT_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_W-1:0]   pattern,
  input  logic [CNT_W-1:0]   repeat_count,
  input  logic [GAP_W-1:0]   gap_cycles,
  input  logic               abort,
  output logic               output_bit,
  output logic               bit_valid,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] present_state
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [IDX_W-1:0]   bit_idx, bit_idx_d;
  logic [CNT_W-1:0]   rep_left, rep_left_d;
  logic [GAP_W-1:0]   gap_len, gap_len_d;
  logic [GAP_W-1:0]   gap_left, gap_left_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   load_data;
  logic               load, shift, next_msb;

  seq_piso_shift #(.W(PAT_W)) u_piso (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (load_data),
    .next_msb  (next_msb)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state;
    bit_idx_d  = bit_idx;
    rep_left_d = rep_left;
    gap_len_d  = gap_len;
    gap_left_d = gap_left;
    pat_d      = pat_q;
    load_data  = pat_q;
    load       = 1'b0;
    shift      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          pat_d      = pattern;
          rep_left_d = repeat_count;
          gap_len_d  = gap_cycles;
          load_data  = pattern;
          bit_idx_d  = '0;
          if (repeat_count != '0) begin
            load    = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SEND: begin
        if (bit_idx == LAST_IDX) begin
          bit_idx_d = '0;
          if (rep_left > CNT_W'(1)) begin
            rep_left_d = rep_left - CNT_W'(1);
            // Zero gap reloads straight away so the next MSB follows the LSB directly.
            if (gap_len == '0) begin
              load = 1'b1;
            end else begin
              gap_left_d = gap_len;
              state_d    = ST_GAP;
            end
          end else begin
            rep_left_d = '0;
            state_d    = ST_DONE;
          end
        end else begin
          shift     = 1'b1;
          bit_idx_d = bit_idx + IDX_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_left <= GAP_W'(1)) begin
          gap_left_d = '0;
          load       = 1'b1;
          state_d    = ST_SEND;
        end else begin
          gap_left_d = gap_left - GAP_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Abort only matters once a transfer is under way; start wins in IDLE.
    if (abort && (state != ST_IDLE)) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      shift   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      rep_left   <= '0;
      gap_len    <= '0;
      gap_left   <= '0;
      pat_q      <= '0;
      output_bit <= IDLE_BIT;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      bit_idx    <= bit_idx_d;
      rep_left   <= rep_left_d;
      gap_len    <= gap_len_d;
      gap_left   <= gap_left_d;
      pat_q      <= pat_d;
      output_bit <= (state_d == ST_SEND) ? next_msb : IDLE_BIT;
      bit_valid  <= (state_d == ST_SEND);
      busy       <= is_busy_state(state_d);
      done       <= (state_d == ST_DONE);
    end
  end

  assign present_state = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: each accepted transfer is expanded into its
// expected cycle-by-cycle output trace; a negedge monitor pops and compares.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 4;
  localparam int   GAP_W    = 4;
  localparam logic IDLE_BIT = 1'b0;
  localparam int   WAIT_MAX = 10;

  typedef struct packed {
    logic               valid;
    logic               data;
    logic               busy;
    logic               done;
    logic [STATE_W-1:0] state;
  } obs_t;

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [PAT_W-1:0]   pattern;
  logic [CNT_W-1:0]   repeat_count;
  logic [GAP_W-1:0]   gap_cycles;
  logic               output_bit, bit_valid, busy, done;
  logic [STATE_W-1:0] present_state;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .repeat_count  (repeat_count),
    .gap_cycles    (gap_cycles),
    .abort         (abort),
    .output_bit    (output_bit),
    .bit_valid     (bit_valid),
    .busy          (busy),
    .done          (done),
    .present_state (present_state)
  );

  // exp_q[0] is always the record for the cycle currently in progress.
  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic check(input bit ok, input string msg);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @%0t", msg, $time);
    end
  endtask

  function automatic obs_t idle_rec();
    obs_t r;
    r = '{valid: 1'b0, data: IDLE_BIT, busy: 1'b0, done: 1'b0, state: ST_IDLE};
    return r;
  endfunction

  // Reference model: a transfer is cnt repetitions of PAT_W bits, gap idle cycles
  // between repetitions, then one done cycle.
  function automatic void push_transfer(input logic [PAT_W-1:0] pat, input int cnt,
                                        input int gap);
    obs_t r;
    for (int rep = 0; rep < cnt; rep++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        r = '{valid: 1'b1, data: pat[b], busy: 1'b1, done: 1'b0, state: ST_SEND};
        exp_q.push_back(r);
      end
      if (rep < cnt - 1) begin
        for (int g = 0; g < gap; g++) begin
          r = '{valid: 1'b0, data: IDLE_BIT, busy: 1'b1, done: 1'b0, state: ST_GAP};
          exp_q.push_back(r);
        end
      end
    end
    r = '{valid: 1'b0, data: IDLE_BIT, busy: 1'b1, done: 1'b1, state: ST_DONE};
    exp_q.push_back(r);
  endfunction

  function automatic void truncate();
    while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
  endfunction

  // Drive one cycle of inputs and update the model for the coming edge.
  task automatic step(input logic st, input logic ab, input logic rs,
                      input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] cnt,
                      input logic [GAP_W-1:0] gap);
    bit busy_now;
    start        = st;
    abort        = ab;
    reset        = rs;
    pattern      = pat;
    repeat_count = cnt;
    gap_cycles   = gap;
    busy_now = (exp_q.size() != 0) && exp_q[0].busy;
    if (rs) truncate();
    else if (!busy_now && st) push_transfer(pat, int'(cnt), int'(gap));
    else if (busy_now && ab) truncate();
    if (exp_q.size() < 2) exp_q.push_back(idle_rec());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, PAT_W'($urandom), '0, '0);
  endtask

  task automatic go(input logic [PAT_W-1:0] pat, input int cnt, input int gap);
    step(1'b1, 1'b0, 1'b0, pat, CNT_W'(cnt), GAP_W'(gap));
  endtask

  task automatic check_reset_state(input string tag);
    check((output_bit === IDLE_BIT) && (bit_valid === 1'b0) && (busy === 1'b0) &&
          (done === 1'b0) && (present_state === ST_IDLE),
          $sformatf("%s: reset state got bit=%b valid=%b busy=%b done=%b state=%0d",
                    tag, output_bit, bit_valid, busy, done, present_state));
  endtask

  // Monitor: compares the full observable output set once per cycle.
  obs_t m_exp, m_act;
  always @(negedge clk) begin
    if (mon_en) begin
      m_act = {bit_valid, output_bit, busy, done, present_state};
      if (exp_q.size() == 0) m_exp = idle_rec();
      else m_exp = exp_q.pop_front();
      check(m_act === m_exp,
            $sformatf("trace: got valid=%b bit=%b busy=%b done=%b state=%0d, required valid=%b bit=%b busy=%b done=%b state=%0d",
                      m_act.valid, m_act.data, m_act.busy, m_act.done, m_act.state,
                      m_exp.valid, m_exp.data, m_exp.busy, m_exp.done, m_exp.state));
    end
  end

  initial begin
    logic             r_st, r_ab, r_rs;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    int               waited;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_count = '0; gap_cycles = '0;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(idle_rec());
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0, '0, '0);
    check_reset_state("initial");
    idle(2);

    // Single repetition, waiting a bounded time for done, then back-to-back repetitions.
    go(4'b1010, 1, 0);
    waited = 0;
    while ((done !== 1'b1) && (waited < WAIT_MAX)) begin
      idle(1);
      waited++;
    end
    check(waited < WAIT_MAX, "wait for done expired");
    idle(7);
    go(4'b1010, 3, 0);  idle(15);
    // Repetitions separated by a two-cycle gap.
    go(4'b1101, 2, 2);  idle(12);
    // Abort after two bits, with a start pulsed while busy.
    go(4'b1101, 2, 0);
    step(1'b1, 1'b0, 1'b0, 4'b0110, 4'd3, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 4'd0);
    idle(4);
    // Zero repetitions, then start+abort together in IDLE.
    go(4'b1111, 0, 3);  idle(3);
    step(1'b1, 1'b1, 1'b0, 4'b1010, 4'd2, 4'd1);
    idle(12);
    // Start during the done cycle is ignored; one cycle later it is honoured.
    go(4'b0011, 1, 0);  idle(4);
    go(4'b1001, 1, 0);
    go(4'b0110, 1, 0);  idle(7);
    // Reset held two cycles mid-transfer.
    go(4'b1011, 3, 1);  idle(3);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 4'd5, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 4'd5, 4'd0);
    check_reset_state("mid-transfer");
    idle(2);
    // Longest transfer: maximum repetitions and gap.
    go(4'b1000, 15, 15); idle(300);

    for (int i = 0; i < 1500; i++) begin
      r_st  = ($urandom_range(3) == 0);
      r_ab  = ($urandom_range(39) == 0);
      r_rs  = ($urandom_range(149) == 0);
      r_cnt = ($urandom_range(3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(3));
      r_gap = ($urandom_range(1) == 0) ? GAP_W'(0) : GAP_W'($urandom_range(4));
      step(r_st, r_ab, r_rs, PAT_W'($urandom), r_cnt, r_gap);
    end
    idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
